// File: rtl/ddr3_burst_writer_pkg.sv
// Shared types and AXI3 constants for the DDR3 burst writer.
package ddr3_burst_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_FULL
  } wr_state_t;

  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/ddr3_burst_writer_if.sv
// AXI3 write-channel bundle between the burst writer and the DDR3 controller slave port.
interface ddr3_burst_writer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;
  logic [63:0]       wdata;
  logic [7:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bvalid, bresp,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bvalid, bresp,
    input  bready
  );
endinterface

// File: rtl/ddr3_burst_writer_beat_counter.sv
// Counts accepted W beats within a burst; flags the last beat and the burst-done strobe.
module axi_beat_counter #(
  parameter int unsigned BURST_LEN = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic beat_fire,
  output logic wlast,
  output logic done
);

  logic [3:0] beat;

  assign wlast = active & (beat == 4'(BURST_LEN - 1));
  assign done  = beat_fire & wlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat <= '0;
    end else if (done) begin
      beat <= '0;
    end else if (beat_fire) begin
      beat <= beat + 4'd1;
    end
  end

endmodule

// File: rtl/ddr3_burst_writer.sv
// Drains the 64-bit FWFT TEMPFIFO into a circular DDR3 region as fixed-length AXI3 INCR bursts,
// one burst outstanding at a time, and reports region-full back to the DIGIFIFO converter.
module ddr3_burst_writer
  import ddr3_burst_writer_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       BURST_LEN = 16,
  parameter int unsigned       MEM_WORDS = 32'h0010_0000,
  localparam int unsigned      PTR_W     = $clog2(MEM_WORDS) + 1
) (
  input  logic             ddrclk_i,
  input  logic             resetn_i,
  input  logic             fifo_write_mem_en,
  input  logic             mem_read_done,
  input  logic [63:0]      tempfifo_rdata,
  input  logic             tempfifo_empty,
  input  logic [10:0]      tempfifo_rdcnt,
  output logic             tempfifo_re,
  ddr3_burst_writer_if.master axi,
  output logic             DDR3_full,
  output logic             last_write,
  output logic [PTR_W-1:0] wr_ptr,
  output logic             wr_err
);

  wr_state_t        state;
  logic             data_en;
  logic             beat_fire;
  logic             burst_done;
  logic [PTR_W-1:0] ptr_next;

  assign axi.awlen   = 4'(BURST_LEN - 1);
  assign axi.awsize  = SIZE_8B;
  assign axi.awburst = BURST_INCR;
  assign axi.wstrb   = '1;
  assign axi.wdata   = tempfifo_rdata;

  // W is only offered while the FWFT head is valid, so a pop always matches an accepted beat.
  assign data_en     = (state == ST_DATA);
  assign axi.wvalid  = data_en & ~tempfifo_empty;
  assign beat_fire   = axi.wvalid & axi.wready;
  assign tempfifo_re = beat_fire & ~tempfifo_empty;
  assign ptr_next    = wr_ptr + PTR_W'(BURST_LEN);

  axi_beat_counter #(
    .BURST_LEN (BURST_LEN)
  ) u_beat_counter (
    .clk       (ddrclk_i),
    .rst_n     (resetn_i),
    .active    (data_en),
    .beat_fire (beat_fire),
    .wlast     (axi.wlast),
    .done      (burst_done)
  );

  always_ff @(posedge ddrclk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state       <= ST_IDLE;
      axi.awvalid <= 1'b0;
      axi.awaddr  <= '0;
      axi.bready  <= 1'b0;
      wr_ptr      <= '0;
      DDR3_full   <= 1'b0;
      last_write  <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      last_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fifo_write_mem_en && !DDR3_full && (tempfifo_rdcnt >= 11'(BURST_LEN))) begin
            state       <= ST_ADDR;
            axi.awvalid <= 1'b1;
            axi.awaddr  <= BASE_ADDR + (ADDR_W'(wr_ptr) << 3);
          end
        end
        ST_ADDR: begin
          if (axi.awready) begin
            axi.awvalid <= 1'b0;
            state       <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (burst_done) begin
            axi.bready <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (axi.bvalid) begin
            axi.bready <= 1'b0;
            if (axi.bresp != RESP_OKAY) begin
              wr_err <= 1'b1;
            end
            // Bursts are whole-burst aligned, so the region end is hit exactly, never overshot.
            if (ptr_next == PTR_W'(MEM_WORDS)) begin
              wr_ptr     <= '0;
              last_write <= 1'b1;
              DDR3_full  <= 1'b1;
              state      <= ST_FULL;
            end else begin
              wr_ptr <= ptr_next;
              state  <= ST_IDLE;
            end
          end
        end
        ST_FULL: begin
          if (mem_read_done) begin
            DDR3_full <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_burst_writer.sv
// Self-checking bench for ddr3_burst_writer: FIFO model, AXI slave model and a W/AW scoreboard.
module tb_ddr3_burst_writer;

  localparam logic [31:0] BASE = 32'h0000_2000;

  logic        clk;
  logic        resetn_i;
  logic        fifo_write_mem_en;
  logic        mem_read_done;
  logic [63:0] tempfifo_rdata;
  logic        tempfifo_empty;
  logic [10:0] tempfifo_rdcnt;
  logic        tempfifo_re;
  logic        DDR3_full;
  logic        last_write;
  logic [6:0]  wr_ptr;
  logic        wr_err;

  ddr3_burst_writer_if #(.ADDR_W(32)) axi ();

  ddr3_burst_writer #(
    .ADDR_W    (32),
    .BASE_ADDR (BASE),
    .BURST_LEN (16),
    .MEM_WORDS (64)
  ) dut (
    .ddrclk_i          (clk),
    .resetn_i          (resetn_i),
    .fifo_write_mem_en (fifo_write_mem_en),
    .mem_read_done     (mem_read_done),
    .tempfifo_rdata    (tempfifo_rdata),
    .tempfifo_empty    (tempfifo_empty),
    .tempfifo_rdcnt    (tempfifo_rdcnt),
    .tempfifo_re       (tempfifo_re),
    .axi               (axi),
    .DDR3_full         (DDR3_full),
    .last_write        (last_write),
    .wr_ptr            (wr_ptr),
    .wr_err            (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec, n_bad;
  int unsigned aw_cnt, b_count, pops, lw_cnt, beat_idx;
  int unsigned wmode, aw_stall;
  logic [1:0]  cur_bresp;
  logic [63:0] fifo_q[$];
  logic [63:0] exp_data[$];
  logic [31:0] exp_addr[$];

  typedef struct {
    int unsigned wmode;
    int unsigned aw_stall;
    logic [1:0]  bresp;
    logic [31:0] addr;
    logic [6:0]  ptr;
    logic        full;
    int unsigned lw;
    logic        err;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh_fifo();
    tempfifo_empty = (fifo_q.size() == 0);
    tempfifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    tempfifo_rdcnt = 11'(fifo_q.size());
  endtask

  task automatic push_words(input int unsigned n);
    logic [63:0] w;
    for (int unsigned i = 0; i < n; i++) begin
      w = {$urandom(), $urandom()};
      fifo_q.push_back(w);
      exp_data.push_back(w);
    end
    refresh_fifo();
  endtask

  task automatic wait_b(input int unsigned target, input string name);
    int unsigned n;
    n = 0;
    while (b_count < target && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    check(name, 64'(b_count >= target), 64'd1);
  endtask

  task automatic wait_beat(input int unsigned idx, input string name);
    int unsigned n;
    n = 0;
    while (beat_idx != idx && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, 64'(beat_idx), 64'(idx));
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // TEMPFIFO read side: a pop sampled mid-cycle takes effect just after the next edge.
  initial begin
    logic [63:0] dummy;
    forever begin
      @(negedge clk);
      if (tempfifo_re === 1'b1) begin
        pops++;
        @(posedge clk); #1;
        if (fifo_q.size() != 0) dummy = fifo_q.pop_front();
        refresh_fifo();
      end
    end
  end

  // AW/W ready driver.
  initial begin
    int unsigned aw_wait;
    aw_wait = 0;
    forever begin
      @(posedge clk); #1;
      aw_wait = (axi.awvalid === 1'b1) ? aw_wait + 1 : 0;
      axi.awready = (aw_stall == 0) ? 1'b1 : (aw_wait > aw_stall);
      axi.wready  = (wmode == 0) ? 1'b1 : ~axi.wready;
    end
  end

  // Write response responder.
  initial begin
    int unsigned k;
    forever begin
      @(negedge clk);
      if (axi.wvalid === 1'b1 && axi.wready === 1'b1 && axi.wlast === 1'b1) begin
        @(posedge clk); #1;
        axi.bvalid = 1'b1;
        axi.bresp  = cur_bresp;
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (axi.bready !== 1'b1 && k < 20);
        @(posedge clk); #1;
        axi.bvalid = 1'b0;
        axi.bresp  = 2'b00;
        b_count++;
      end
    end
  end

  // AW and W scoreboard monitors.
  initial begin
    forever begin
      @(negedge clk);
      if (last_write === 1'b1) lw_cnt++;
      if (axi.awvalid === 1'b1 && axi.awready === 1'b1) begin
        aw_cnt++;
        if (exp_addr.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL aw_unexpected: got addr %0h expected no burst", axi.awaddr);
        end else begin
          check("awaddr", 64'(axi.awaddr), 64'(exp_addr.pop_front()));
        end
      end
      if (axi.wvalid === 1'b1 && exp_data.size() != 0) begin
        if (axi.wready === 1'b1) begin
          check("wdata", axi.wdata, exp_data.pop_front());
          check("wlast", 64'(axi.wlast), 64'(beat_idx == 15));
          beat_idx = (beat_idx + 1) % 16;
        end else begin
          check("wdata_hold", axi.wdata, exp_data[0]);
        end
      end else if (axi.wvalid === 1'b1) begin
        n_vec++; n_bad++;
        $display("FAIL w_unexpected: got beat %0h expected no beat", axi.wdata);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned aw0, p0, l0;
    vecs[0] = '{wmode:0, aw_stall:0, bresp:2'b00, addr:BASE + 32'h000, ptr:7'd16, full:1'b0, lw:0, err:1'b0};
    vecs[1] = '{wmode:1, aw_stall:0, bresp:2'b00, addr:BASE + 32'h080, ptr:7'd32, full:1'b0, lw:0, err:1'b0};
    vecs[2] = '{wmode:0, aw_stall:3, bresp:2'b10, addr:BASE + 32'h100, ptr:7'd48, full:1'b0, lw:0, err:1'b1};
    vecs[3] = '{wmode:0, aw_stall:0, bresp:2'b00, addr:BASE + 32'h180, ptr:7'd0,  full:1'b1, lw:1, err:1'b1};

    n_vec = 0; n_bad = 0; aw_cnt = 0; b_count = 0; pops = 0; lw_cnt = 0; beat_idx = 0;
    wmode = 0; aw_stall = 0; cur_bresp = 2'b00;
    resetn_i = 1'b0; fifo_write_mem_en = 1'b0; mem_read_done = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    refresh_fifo();

    idle_cycles(3);
    check("rst_awvalid", 64'(axi.awvalid), 64'd0);
    check("rst_wvalid", 64'(axi.wvalid), 64'd0);
    check("rst_bready", 64'(axi.bready), 64'd0);
    check("rst_full", 64'(DDR3_full), 64'd0);
    check("rst_wr_ptr", 64'(wr_ptr), 64'd0);
    check("rst_wr_err", 64'(wr_err), 64'd0);
    check("awlen", 64'(axi.awlen), 64'd15);
    check("awsize", 64'(axi.awsize), 64'd3);
    check("awburst", 64'(axi.awburst), 64'd1);
    check("wstrb", 64'(axi.wstrb), 64'hFF);
    resetn_i = 1'b1;
    idle_cycles(2);

    fifo_write_mem_en = 1'b1;
    for (int unsigned v = 0; v < 4; v++) begin
      wmode = vecs[v].wmode; aw_stall = vecs[v].aw_stall; cur_bresp = vecs[v].bresp;
      aw0 = aw_cnt; p0 = pops; l0 = lw_cnt;
      exp_addr.push_back(vecs[v].addr);
      push_words(16);
      wait_b(v + 1, "vec_bresp_timeout");
      idle_cycles(1);
      check("vec_aw_count", 64'(aw_cnt - aw0), 64'd1);
      check("vec_pops", 64'(pops - p0), 64'd16);
      check("vec_wr_ptr", 64'(wr_ptr), 64'(vecs[v].ptr));
      check("vec_full", 64'(DDR3_full), 64'(vecs[v].full));
      check("vec_last_write", 64'(lw_cnt - l0), 64'(vecs[v].lw));
      check("vec_wr_err", 64'(wr_err), 64'(vecs[v].err));
    end
    wmode = 0; aw_stall = 0; cur_bresp = 2'b00;

    // Region full: no burst despite a full TEMPFIFO until mem_read_done.
    aw0 = aw_cnt; p0 = pops;
    push_words(16);
    idle_cycles(40);
    check("full_no_burst", 64'(aw_cnt - aw0), 64'd0);
    check("full_no_pops", 64'(pops - p0), 64'd0);
    check("full_held", 64'(DDR3_full), 64'd1);
    exp_addr.push_back(BASE);
    @(posedge clk); #1 mem_read_done = 1'b1;
    @(posedge clk); #1 mem_read_done = 1'b0;
    check("full_cleared", 64'(DDR3_full), 64'd0);
    wait_b(5, "wrap_bresp_timeout");
    idle_cycles(1);
    check("wrap_wr_ptr", 64'(wr_ptr), 64'd16);
    check("wrap_pops", 64'(pops - p0), 64'd16);

    // Partial FIFO is never written; then enable drops mid-burst.
    aw0 = aw_cnt; p0 = pops;
    push_words(15);
    idle_cycles(30);
    check("partial_no_burst", 64'(aw_cnt - aw0), 64'd0);
    exp_addr.push_back(BASE + 32'h80);
    push_words(1);
    wait_beat(5, "beat5_timeout");
    fifo_write_mem_en = 1'b0;
    wait_b(6, "drop_bresp_timeout");
    idle_cycles(1);
    check("drop_pops", 64'(pops - p0), 64'd16);
    check("drop_wr_ptr", 64'(wr_ptr), 64'd32);
    aw0 = aw_cnt;
    push_words(16);
    idle_cycles(40);
    check("drop_no_burst", 64'(aw_cnt - aw0), 64'd0);
    check("drop_rdcnt", 64'(tempfifo_rdcnt), 64'd16);

    // Asynchronous reset in the middle of a data phase.
    exp_addr.push_back(BASE + 32'h100);
    fifo_write_mem_en = 1'b1;
    wait_beat(3, "beat3_timeout");
    @(posedge clk); #3;
    resetn_i = 1'b0;
    #1;
    check("arst_awvalid", 64'(axi.awvalid), 64'd0);
    check("arst_wvalid", 64'(axi.wvalid), 64'd0);
    check("arst_wlast", 64'(axi.wlast), 64'd0);
    check("arst_re", 64'(tempfifo_re), 64'd0);
    check("arst_bready", 64'(axi.bready), 64'd0);
    check("arst_full", 64'(DDR3_full), 64'd0);
    check("arst_last_write", 64'(last_write), 64'd0);
    check("arst_wr_ptr", 64'(wr_ptr), 64'd0);
    check("arst_wr_err", 64'(wr_err), 64'd0);
    fifo_write_mem_en = 1'b0;
    idle_cycles(2);
    fifo_q.delete(); exp_data.delete(); exp_addr.delete();
    beat_idx = 0;
    refresh_fifo();
    resetn_i = 1'b1;
    idle_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
